// File: rtl/seq_div8_pkg.sv
// Shared constants for the sequential restoring divider: default width and
// FSM state encodings.
package seq_div8_pkg;

  localparam int DIV_WIDTH = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_FIN  = 2'd2;

  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/seq_div8_div_step.sv
// One restoring-division step: trial subtraction T - B done as T + ~B + 1,
// carry-out = 1 meaning T >= B, and the restored partial remainder.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   t,
  input  logic [WIDTH-1:0] b,
  output logic             c,
  output logic [WIDTH-1:0] r_next
);

  logic [WIDTH+1:0] sum;
  logic [WIDTH:0]   diff;
  logic             unused_diff_msb;

  assign sum  = {1'b0, t} + {1'b0, ~{1'b0, b}} + {{(WIDTH+1){1'b0}}, 1'b1};
  assign c    = sum[WIDTH+1];
  assign diff = sum[WIDTH:0];

  // When the subtraction succeeds the difference is below B, so its top bit is always 0.
  assign unused_diff_msb = diff[WIDTH];
  assign r_next = c ? diff[WIDTH-1:0] : t[WIDTH-1:0];

endmodule

// File: rtl/seq_div8.sv
// Sequential unsigned restoring divider with a start/busy/done handshake.
// One quotient bit per cycle; results are registered when leaving FIN.
module seq_div8
  import seq_div8_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH-1:0] div_reg;
  logic [CNT_W-1:0] cnt;
  logic             zero_flag;
  logic             accept;
  logic             step_c;
  logic [WIDTH-1:0] step_r;

  div_step #(.WIDTH(WIDTH)) u_step (
    .t      ({rem_reg, quo_reg[WIDTH-1]}),
    .b      (div_reg),
    .c      (step_c),
    .r_next (step_r)
  );

  // FIN accepts a new start just like IDLE, so operations can run back to back.
  assign accept = start && ((state == ST_IDLE) || (state == ST_FIN));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      rem_reg     <= '0;
      quo_reg     <= '0;
      div_reg     <= '0;
      cnt         <= '0;
      zero_flag   <= 1'b0;
      Quotient    <= '0;
      Remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_FIN: begin
          if (state == ST_FIN) begin
            done        <= 1'b1;
            Quotient    <= quo_reg;
            Remainder   <= rem_reg;
            div_by_zero <= zero_flag;
          end else if (accept) begin
            div_by_zero <= 1'b0;
          end
          if (accept) begin
            div_reg <= B;
            if (B == '0) begin
              quo_reg   <= '1;
              rem_reg   <= A;
              zero_flag <= 1'b1;
              busy      <= 1'b0;
              state     <= ST_FIN;
            end else begin
              quo_reg   <= A;
              rem_reg   <= '0;
              zero_flag <= 1'b0;
              cnt       <= CNT_W'(WIDTH - 1);
              busy      <= 1'b1;
              state     <= ST_RUN;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          rem_reg <= step_r;
          quo_reg <= {quo_reg[WIDTH-2:0], step_c};
          if (cnt == '0) begin
            busy  <= 1'b0;
            state <= ST_FIN;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div8.sv
// Scoreboard bench for seq_div8: stimulus pushes expected results from an
// arithmetic reference model, a negedge monitor pops and compares on done.
module tb_seq_div8;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] A;
  logic [7:0] B;
  logic [7:0] Quotient;
  logic [7:0] Remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  seq_div8 #(.WIDTH(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .A           (A),
    .B           (B),
    .Quotient    (Quotient),
    .Remainder   (Remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
    int         accept;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  int   done_seen = 0;
  bit   excl_on = 1'b0;
  bit   prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input bit ok, input longint act, input longint req);
    checks++;
    if (ok) passes++;
    else $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int ia, ib;
    ia = a;
    ib = b;
    e.a = a;
    e.b = b;
    e.accept = 0;
    if (ib == 0) begin
      e.q = 8'hFF;
      e.r = a;
      e.dbz = 1'b1;
    end else begin
      e.q = 8'(ia / ib);
      e.r = 8'(ia % ib);
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    int prod;
    if (!reset) begin
      if (done) begin
        done_seen++;
        check_output("done_width", !prev_done, prev_done, 0);
        if (excl_on) check_output("busy_done_excl", !busy, busy, 0);
        if (sb.size() == 0) begin
          check_output("unexpected_done", 1'b0, 1, 0);
        end else begin
          e = sb.pop_front();
          check_output("quotient", Quotient == e.q, Quotient, e.q);
          check_output("remainder", Remainder == e.r, Remainder, e.r);
          check_output("div_by_zero", div_by_zero == e.dbz, div_by_zero, e.dbz);
          check_output("latency", (cyc - e.accept) == (e.dbz ? 1 : 9), cyc - e.accept, e.dbz ? 1 : 9);
          if (!e.dbz) begin
            prod = int'(Quotient) * int'(e.b) + int'(Remainder);
            check_output("invariant_qbr", (prod == int'(e.a)) && (Remainder < e.b), prod, e.a);
          end
        end
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic apply_stimulus(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    @(negedge clk);
    A = a;
    B = b;
    start = 1'b1;
    e = model(a, b);
    e.accept = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check_output("wait_timeout", 1'b0, n, 40);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int busy_cnt;
    int seen_before;
    exp_t e;
    reset = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
    repeat (2) @(negedge clk);
    check_output("reset_quotient", Quotient == 8'd0, Quotient, 0);
    check_output("reset_remainder", Remainder == 8'd0, Remainder, 0);
    check_output("reset_busy", busy == 1'b0, busy, 0);
    check_output("reset_done", done == 1'b0, done, 0);
    check_output("reset_dbz", div_by_zero == 1'b0, div_by_zero, 0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] basic division and busy length");
    apply_stimulus(8'd200, 8'd7);
    busy_cnt = busy ? 1 : 0;
    repeat (11) begin
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    check_output("busy_cycles", busy_cnt == 8, busy_cnt, 8);
    wait_idle();

    $display("[TB] corner operands");
    apply_stimulus(8'd255, 8'd1);
    wait_idle();
    apply_stimulus(8'd5, 8'd9);
    wait_idle();
    apply_stimulus(8'd0, 8'd3);
    wait_idle();

    $display("[TB] divide by zero");
    apply_stimulus(8'd42, 8'd0);
    wait_idle();
    apply_stimulus(8'd9, 8'd3);
    wait_idle();

    $display("[TB] reset mid-operation");
    apply_stimulus(8'd100, 8'd10);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    sb.delete();
    seen_before = done_seen;
    @(negedge clk);
    check_output("abort_quotient", Quotient == 8'd0, Quotient, 0);
    check_output("abort_remainder", Remainder == 8'd0, Remainder, 0);
    check_output("abort_busy", busy == 1'b0, busy, 0);
    check_output("abort_dbz", div_by_zero == 1'b0, div_by_zero, 0);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check_output("abort_no_done", done_seen == seen_before, done_seen - seen_before, 0);
    apply_stimulus(8'd100, 8'd10);
    wait_idle();

    $display("[TB] ignored starts and back-to-back");
    apply_stimulus(8'd50, 8'd5);
    repeat (5) begin
      @(negedge clk);
      start = 1'b1;
      A = 8'd1;
      B = 8'd1;
    end
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    A = 8'd17;
    B = 8'd4;
    start = 1'b1;
    e = model(8'd17, 8'd4);
    e.accept = cyc + 2;
    sb.push_back(e);
    repeat (2) @(negedge clk);
    start = 1'b0;
    wait_idle();

    $display("[TB] random operations");
    excl_on = 1'b1;
    repeat (1000) begin
      apply_stimulus(8'($urandom_range(0, 255)), 8'($urandom_range(1, 255)));
      wait_idle();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
